// File: rtl/rv_structs.sv
// +----------------------------------------------------------------------------
// | rv_structs : shared types and constants for the RV32M divide group
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package rv_structs;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPECIAL = 3'd1,
    CALC    = 3'd2,
    FIX     = 3'd3,
    DONE    = 3'd4
  } div_state_e;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam int DIV_CYCLES = 32;

endpackage

`default_nettype wire

// File: rtl/alu_div_step.sv
// +----------------------------------------------------------------------------
// | alu_div_step : one combinational restoring-division iteration
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module alu_div_step (
  input  logic [32:0] i_prem,
  input  logic [31:0] i_divisor,
  input  logic        i_bit,
  output logic [32:0] o_prem,
  output logic        o_qbit
);

  logic [33:0] w_shift;
  logic [32:0] w_sub;

  // Truncating the subtraction to 33 bits is safe: it is only kept when
  // shift >= divisor, so the true difference is below the divisor.
  assign w_shift = {i_prem, i_bit};
  assign o_qbit  = (w_shift >= {2'b00, i_divisor});
  assign w_sub   = w_shift[32:0] - {1'b0, i_divisor};
  assign o_prem  = o_qbit ? w_sub : w_shift[32:0];

endmodule

`default_nettype wire

// File: rtl/alu_div_seq.sv
// +----------------------------------------------------------------------------
// | alu_div_seq : multi-cycle radix-2 restoring DIV/DIVU/REM/REMU unit
// | Optional result reuse for repeated operands: define DIV_RESULT_CACHE_EN
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module alu_div_seq
  import rv_structs::*;
#(
  parameter int DIV_ITER_BITS = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_div,
  output logic [31:0] o_rem
);

  localparam logic [4:0] c_count_init = 5'(DIV_CYCLES - 1);

  generate
    if (DIV_ITER_BITS != 1) begin : g_iter_check
      $error("alu_div_seq: only DIV_ITER_BITS == 1 is supported");
    end
  endgenerate

  div_state_e  r_state;
  logic [4:0]  r_count;
  logic [31:0] r_quo;      // dividend shifting out, quotient shifting in
  logic [31:0] r_divisor;
  logic [32:0] r_prem;
  logic        r_q_neg;
  logic        r_r_neg;

  logic        w_grp_ok;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_prem_nxt;
  logic        w_qbit;

  assign w_grp_ok = (i_funct3 == F3_DIV) || (i_funct3 == F3_DIVU) ||
                    (i_funct3 == F3_REM) || (i_funct3 == F3_REMU);
  assign w_signed = (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
  assign w_a_neg  = w_signed & i_op1[31];
  assign w_b_neg  = w_signed & i_op2[31];
  assign w_abs1   = w_a_neg ? (~i_op1 + 32'd1) : i_op1;
  assign w_abs2   = w_b_neg ? (~i_op2 + 32'd1) : i_op2;

`ifdef DIV_RESULT_CACHE_EN
  logic [31:0] r_c_op1;
  logic [31:0] r_c_op2;
  logic        r_c_signed;
  logic        r_c_valid;
  logic        w_hit;

  assign w_hit = r_c_valid && (i_op1 == r_c_op1) && (i_op2 == r_c_op2) &&
                 (w_signed == r_c_signed);
`endif

  alu_div_step u_step (
    .i_prem    (r_prem),
    .i_divisor (r_divisor),
    .i_bit     (r_quo[31]),
    .o_prem    (w_prem_nxt),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_count   <= 5'd0;
      r_quo     <= 32'd0;
      r_divisor <= 32'd0;
      r_prem    <= 33'd0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_div     <= 32'd0;
      o_rem     <= 32'd0;
`ifdef DIV_RESULT_CACHE_EN
      r_c_op1    <= 32'd0;
      r_c_op2    <= 32'd0;
      r_c_signed <= 1'b0;
      r_c_valid  <= 1'b0;
`endif
    end else if (i_flush) begin
      r_state <= IDLE;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
      if (r_state == CALC) r_c_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_start && w_grp_ok) begin
`ifdef DIV_RESULT_CACHE_EN
            if (w_hit) begin
              r_state <= DONE;
              o_valid <= 1'b1;
            end else begin
              r_c_op1    <= i_op1;
              r_c_op2    <= i_op2;
              r_c_signed <= w_signed;
              r_c_valid  <= 1'b0;
`endif
              o_busy    <= 1'b1;
              r_q_neg   <= w_a_neg ^ w_b_neg;
              r_r_neg   <= w_a_neg;
              r_divisor <= w_abs2;
              r_count   <= c_count_init;
              if (i_op2 == 32'd0) begin
                r_quo   <= 32'hFFFF_FFFF;
                r_prem  <= {1'b0, i_op1};
                r_state <= SPECIAL;
              end else if (w_signed && (i_op1 == 32'h8000_0000) &&
                           (i_op2 == 32'hFFFF_FFFF)) begin
                r_quo   <= 32'h8000_0000;
                r_prem  <= 33'd0;
                r_state <= SPECIAL;
              end else begin
                r_quo   <= w_abs1;
                r_prem  <= 33'd0;
                r_state <= CALC;
              end
`ifdef DIV_RESULT_CACHE_EN
            end
`endif
          end
        end
        // Special results are final as loaded, so no sign fix-up is applied
        SPECIAL: begin
          o_div   <= r_quo;
          o_rem   <= r_prem[31:0];
          o_busy  <= 1'b0;
          o_valid <= 1'b1;
          r_state <= DONE;
`ifdef DIV_RESULT_CACHE_EN
          r_c_valid <= 1'b1;
`endif
        end
        CALC: begin
          r_prem <= w_prem_nxt;
          r_quo  <= {r_quo[30:0], w_qbit};
          if (r_count == 5'd0) r_state <= FIX;
          else                 r_count <= r_count - 5'd1;
        end
        FIX: begin
          o_div   <= r_q_neg ? (~r_quo + 32'd1) : r_quo;
          o_rem   <= r_r_neg ? (~r_prem[31:0] + 32'd1) : r_prem[31:0];
          o_busy  <= 1'b0;
          o_valid <= 1'b1;
          r_state <= DONE;
`ifdef DIV_RESULT_CACHE_EN
          r_c_valid <= 1'b1;
`endif
        end
        DONE: begin
          o_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
